simd_word_sequencer: RTL

SIMD_WORD_SEQUENCER -- requirements
Module: simd_word_sequencer

---
 rtl/simd_word_sequencer_pkg.sv | 7 +
 rtl/simd_word_sequencer_if.sv | 26 ++
 rtl/simd_word_sequencer.sv | 54 +++++
 3 files changed

// File: rtl/simd_word_sequencer_pkg.sv
// simd_pkg: shared constants and types for the SIMD word sequencer
package simd_pkg;
  localparam int WORD_W = 32;
  localparam int WORDS = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  typedef logic [1:0] alu_op_t;
endpackage

// File: rtl/simd_word_sequencer_if.sv
// simd_word_sequencer_if: input block, output block and external ALU bus
interface simd_word_sequencer_if #(
  parameter int WORDS = simd_pkg::WORDS,
  parameter int WORD_W = simd_pkg::WORD_W
);
  logic in_valid;
  logic in_ready;
  logic [WORDS*WORD_W-1:0] in_a;
  logic [WORDS*WORD_W-1:0] in_b;
  simd_pkg::alu_op_t in_op;
  logic [WORD_W-1:0] alu_a;
  logic [WORD_W-1:0] alu_b;
  simd_pkg::alu_op_t alu_select;
  logic [WORD_W-1:0] alu_result;
  logic out_valid;
  logic out_ready;
  logic [WORDS*WORD_W-1:0] out_data;
  modport slave (
    input in_valid, in_a, in_b, in_op, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_select, out_valid, out_data
  );
  modport master (
    output in_valid, in_a, in_b, in_op, alu_result, out_ready,
    input in_ready, alu_a, alu_b, alu_select, out_valid, out_data
  );
endinterface

// File: rtl/simd_word_sequencer.sv
// simd_word_sequencer: streams a block one word per cycle through an external ALU and reassembles the result
module simd_word_sequencer #(
  parameter int WORDS = simd_pkg::WORDS,
  parameter int WORD_W = simd_pkg::WORD_W
) (
  input logic clk,
  input logic rst_n,
  simd_word_sequencer_if.slave bus,
  output logic busy
);
  import simd_pkg::*;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [WORDS-1:0][WORD_W-1:0] a_q, b_q, res_q;
  alu_op_t op_q;
  logic last;
  assign last = idx == IW'(WORDS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.in_valid) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
        op_q <= bus.in_op;
        idx <= '0;
      end
      if (state == ISSUE) begin
        res_q[idx] <= bus.alu_result;
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && bus.in_valid) nxt = ISSUE;
    if (state == ISSUE && last) nxt = DONE;
    if (state == DONE && bus.out_ready) nxt = IDLE;
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    busy = state != IDLE;
    bus.alu_a = state == ISSUE ? a_q[idx] : '0;
    bus.alu_b = state == ISSUE ? b_q[idx] : '0;
    bus.alu_select = op_q;
    bus.out_data = res_q;
  end
endmodule
